// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle ALU with a valid/ready handshake on both sides.
//
// Single-cycle ops (and, or, add, sub, xor, sll, srl, sltu, slt, sgeq) and
// undefined opcodes complete one cycle after accept. mul is an iterative
// shift-add that completes WIDTH+1 cycles after accept. divu/remu use a
// restoring divider with the same WIDTH+1 latency.
//
// Configuration macro: ALU_MC_DIV_EN
//   defined   -> divider datapath and DIV state are built.
//   undefined -> divu/remu behave like undefined opcodes, but raise overflow.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous active-high reset
//   in_valid   operation request
//   in_ready   block can accept (IDLE, or DONE while out_ready is high)
//   op[4:0]    opcode
//   a, b       operands, captured on accept
//   out_valid  result valid (DONE state)
//   out_ready  consumer takes the result
//   result     registered result
//   carryout, overflow, zero, set   registered flags
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             set
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_SUB  = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SLTU = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SGEQ = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIVU = 5'b10010;
    localparam logic [4:0] OP_REMU = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             carry;
        logic             ovf;
        logic             set;
    } alu_res_t;

    // Combinational evaluation of every op that completes in one cycle.
    function automatic alu_res_t alu_single(input logic [4:0]       op_i,
                                            input logic [WIDTH-1:0] a_i,
                                            input logic [WIDTH-1:0] b_i);
        alu_res_t         r_v;
        logic [WIDTH:0]   ext_v;
        logic             lt_u_v;
        logic             lt_s_v;
        r_v    = '0;
        ext_v  = '0;
        lt_u_v = (a_i < b_i);
        lt_s_v = ($signed(a_i) < $signed(b_i));
        case (op_i)
            OP_AND:  r_v.res = a_i & b_i;
            OP_OR:   r_v.res = a_i | b_i;
            OP_XOR:  r_v.res = a_i ^ b_i;
            OP_ADD: begin
                ext_v     = {1'b0, a_i} + {1'b0, b_i};
                r_v.res   = ext_v[WIDTH-1:0];
                r_v.carry = ext_v[WIDTH];
                r_v.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                            (ext_v[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // a + ~b + 1: the carry out is the "no borrow" bit.
                ext_v     = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
                r_v.res   = ext_v[WIDTH-1:0];
                r_v.carry = ext_v[WIDTH];
                r_v.ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                            (ext_v[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SLL:  r_v.res = a_i << b_i[SHW-1:0];
            OP_SRL:  r_v.res = a_i >> b_i[SHW-1:0];
            OP_SLTU: begin
                r_v.res = {{(WIDTH-1){1'b0}}, lt_u_v};
                r_v.set = lt_u_v;
            end
            OP_SLT: begin
                r_v.res = {{(WIDTH-1){1'b0}}, lt_s_v};
                r_v.set = lt_s_v;
            end
            OP_SGEQ: begin
                r_v.res = {{(WIDTH-1){1'b0}}, ~lt_s_v};
                r_v.set = ~lt_s_v;
            end
`ifndef ALU_MC_DIV_EN
            // Divider not built: flag the request as unserviceable.
            OP_DIVU, OP_REMU: r_v.ovf = 1'b1;
`endif
            default: r_v = '0;
        endcase
        return r_v;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    state_t           start_state_s;
    logic             accept_s;
    logic [SHW-1:0]   cnt_r;
    logic             last_s;
    alu_res_t         single_s;

    logic             load_s;
    logic [WIDTH-1:0] res_nxt_s;
    logic             carry_nxt_s;
    logic             ovf_nxt_s;
    logic             set_nxt_s;

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nxt_s;
    logic             mul_done_s;

    logic             div_done_s;
    logic [WIDTH-1:0] div_res_s;
    logic             div_ovf_s;

    assign in_ready   = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s   = in_valid && in_ready;
    assign out_valid  = (state_r == DONE);
    assign last_s     = (cnt_r == SHW'(WIDTH - 1));
    assign single_s   = alu_single(op, a, b);
    assign acc_nxt_s  = acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
    assign mul_done_s = (state_r == MUL) && last_s;

    // Decode which state an accepted opcode starts in.
    always_comb begin
        start_state_s = DONE;
        case (op)
            OP_MUL:  start_state_s = MUL;
`ifdef ALU_MC_DIV_EN
            OP_DIVU, OP_REMU: start_state_s = DIV;
`endif
            default: start_state_s = DONE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = start_state_s;
                else          state_nxt_s = IDLE;
            end
            MUL: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = MUL;
            end
            DIV: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = DIV;
            end
            DONE: begin
                if (accept_s)       state_nxt_s = start_state_s;
                else if (out_ready) state_nxt_s = IDLE;
                else                state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Iteration counter shared by the multiplier and divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= '0;
        end else if ((state_r == MUL) || (state_r == DIV)) begin
            cnt_r <= cnt_r + SHW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Shift-add multiplier: one multiplier bit per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
        end else if (accept_s && (start_state_s == MUL)) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= '0;
        end else if (state_r == MUL) begin
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_nxt_s;
        end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
        end
    end

`ifdef ALU_MC_DIV_EN
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvsr_r;
    logic             is_rem_r;
    logic [WIDTH:0]   partial_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign partial_s  = {rem_r, quo_r[WIDTH-1]};
    assign diff_s     = partial_s - {1'b0, dvsr_r};
    assign rem_step_s = diff_s[WIDTH] ? partial_s[WIDTH-1:0] : diff_s[WIDTH-1:0];
    assign quo_step_s = {quo_r[WIDTH-2:0], ~diff_s[WIDTH]};
    assign div_done_s = (state_r == DIV) && last_s;
    assign div_ovf_s  = (dvsr_r == {WIDTH{1'b0}});
    // With a zero divisor every trial subtract succeeds, so the remainder
    // naturally ends up equal to the dividend; the quotient is forced.
    assign div_res_s  = is_rem_r  ? rem_step_s :
                        div_ovf_s ? {WIDTH{1'b1}} : quo_step_s;

    // Restoring divider registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_r    <= '0;
            rem_r    <= '0;
            dvsr_r   <= '0;
            is_rem_r <= 1'b0;
        end else if (accept_s && (start_state_s == DIV)) begin
            quo_r    <= a;
            rem_r    <= '0;
            dvsr_r   <= b;
            is_rem_r <= (op == OP_REMU);
        end else if (state_r == DIV) begin
            quo_r    <= quo_step_s;
            rem_r    <= rem_step_s;
            dvsr_r   <= dvsr_r;
            is_rem_r <= is_rem_r;
        end else begin
            quo_r    <= quo_r;
            rem_r    <= rem_r;
            dvsr_r   <= dvsr_r;
            is_rem_r <= is_rem_r;
        end
    end
`else
    assign div_done_s = 1'b0;
    assign div_res_s  = {WIDTH{1'b0}};
    assign div_ovf_s  = 1'b0;
`endif

    // Select what, if anything, is written into the output registers.
    always_comb begin
        load_s      = 1'b0;
        res_nxt_s   = result;
        carry_nxt_s = 1'b0;
        ovf_nxt_s   = 1'b0;
        set_nxt_s   = 1'b0;
        if (accept_s && (start_state_s == DONE)) begin
            load_s      = 1'b1;
            res_nxt_s   = single_s.res;
            carry_nxt_s = single_s.carry;
            ovf_nxt_s   = single_s.ovf;
            set_nxt_s   = single_s.set;
        end else if (mul_done_s) begin
            load_s      = 1'b1;
            res_nxt_s   = acc_nxt_s;
        end else if (div_done_s) begin
            load_s      = 1'b1;
            res_nxt_s   = div_res_s;
            ovf_nxt_s   = div_ovf_s;
        end else begin
            load_s      = 1'b0;
        end
    end

    // Output registers: loaded on completion, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            set      <= 1'b0;
        end else if (load_s) begin
            result   <= res_nxt_s;
            carryout <= carry_nxt_s;
            overflow <= ovf_nxt_s;
            zero     <= (res_nxt_s == {WIDTH{1'b0}});
            set      <= set_nxt_s;
        end else begin
            result   <= result;
            carryout <= carryout;
            overflow <= overflow;
            zero     <= zero;
            set      <= set;
        end
    end

endmodule
